// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator controller and its call panel.
// Floor codes, direction constants and the call-panel state enum.
package elevator_pkg;

    typedef enum logic [1:0] {
        F0 = 2'd0,
        F1 = 2'd1,
        F2 = 2'd2,
        F3 = 2'd3
    } floor_e;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DWELL = 2'd2
    } panel_state_e;

    function automatic logic [3:0] floor_bit(input logic [1:0] f);
        return 4'b0001 << f;
    endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Signal bundle between buttons/controller and the call panel.
// slave = panel side, master = driver of buttons and controller status.
interface elevator_call_panel_if;

    logic [3:0] btn;
    logic [1:0] floor;
    logic       dir;
    logic       ra;
    logic       rb;
    logic       rc;
    logic       rd;
    logic [3:0] pending;
    logic       door_open;
    logic       busy;

    modport slave (
        input  btn,
        input  floor,
        input  dir,
        output ra,
        output rb,
        output rc,
        output rd,
        output pending,
        output door_open,
        output busy
    );

    modport master (
        output btn,
        output floor,
        output dir,
        input  ra,
        input  rb,
        input  rc,
        input  rd,
        input  pending,
        input  door_open,
        input  busy
    );

endinterface

// File: rtl/elevator_call_panel_scan_pick.sv
// SCAN target selection: continue in the current direction, else reverse.
// The current floor itself is never picked; the panel serves it directly.
module scan_pick
    import elevator_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] floor,
    input  logic       dir,
    output logic [1:0] target,
    output logic       valid
);

    logic [1:0] above_t;
    logic [1:0] below_t;
    logic       above_v;
    logic       below_v;

    always_comb begin
        above_t = '0;
        above_v = 1'b0;
        below_t = '0;
        below_v = 1'b0;
        // Descending scan leaves the nearest floor above in above_t
        for (int i = 3; i >= 0; i--) begin
            if (pending[i] && (i > int'(floor))) begin
                above_v = 1'b1;
                above_t = i[1:0];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pending[i] && (i < int'(floor))) begin
                below_v = 1'b1;
                below_t = i[1:0];
            end
        end
        valid = above_v | below_v;
        if (dir == DOWN) begin
            target = below_v ? below_t : above_t;
        end else begin
            target = above_v ? above_t : below_t;
        end
    end

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: pending-call register, SCAN target FSM and door dwell timer.
// Drives one registered request line toward the controller per trip.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input logic                   clk,
    input logic                   rst,
    elevator_call_panel_if.slave  bus
);

    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    panel_state_e  state_q;
    panel_state_e  state_d;
    logic [1:0]    target_q;
    logic [1:0]    target_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    pending_q;
    logic [3:0]    pending_d;
    logic [3:0]    req_q;
    logic [3:0]    req_d;
    logic          door_q;
    logic          busy_q;
    logic [3:0]    clr;
    logic [1:0]    pick_target;
    logic          pick_valid;

    scan_pick u_pick (
        .pending (pending_q),
        .floor   (bus.floor),
        .dir     (bus.dir),
        .target  (pick_target),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        clr      = '0;
        unique case (state_q)
            IDLE: begin
                if (pending_q[bus.floor]) begin
                    state_d = DWELL;
                    clr     = floor_bit(bus.floor);
                    cnt_d   = DWELL_LOAD;
                end else if (pick_valid) begin
                    state_d  = REQ;
                    target_d = pick_target;
                end
            end
            REQ: begin
                if (bus.floor == target_q) begin
                    state_d = DWELL;
                    clr     = floor_bit(target_q);
                    cnt_d   = DWELL_LOAD;
                end
            end
            DWELL: begin
                // Holding the current floor's clear absorbs repeat presses
                clr = floor_bit(bus.floor);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pending_d = (pending_q | bus.btn) & ~clr;
        req_d     = (state_d == REQ) ? floor_bit(target_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            req_q     <= '0;
            door_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            door_q    <= (state_d == DWELL);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.ra        = req_q[0];
    assign bus.rb        = req_q[1];
    assign bus.rc        = req_q[2];
    assign bus.rd        = req_q[3];
    assign bus.pending   = pending_q;
    assign bus.door_open = door_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Scoreboard bench for elevator_call_panel with a one-edge-lag controller model.
// Each scenario queues per-cycle expectations and compares after every edge.
module tb_elevator_call_panel;
    import elevator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    elevator_call_panel_if bus ();

    elevator_call_panel #(
        .DWELL_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] pend;
        logic       door;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [3:0] btn;
        logic       dir;
        logic       rst;
        obs_t       exp;
    } step_t;

    int         tests = 0;
    int         fails = 0;
    obs_t       sb[$];
    step_t      plan[$];
    bit         mv = 1'b0;
    logic [1:0] mv_to = 2'd0;

    function automatic obs_t sample();
        obs_t o;
        o.req  = {bus.rd, bus.rc, bus.rb, bus.ra};
        o.pend = bus.pending;
        o.door = bus.door_open;
        o.busy = bus.busy;
        return o;
    endfunction

    function automatic step_t st(input logic [3:0] b, input logic d,
                                 input logic [3:0] q, input logic [3:0] p,
                                 input logic dr, input logic bz,
                                 input logic r = 1'b1);
        step_t s;
        s.btn      = b;
        s.dir      = d;
        s.rst      = r;
        s.exp.req  = q;
        s.exp.pend = p;
        s.exp.door = dr;
        s.exp.busy = bz;
        return s;
    endfunction

    // Controller model: a request seen in one cycle moves floor at the next edge
    task automatic clk_step();
        obs_t o;
        @(posedge clk);
        #1;
        if (mv) bus.floor = mv_to;
        o  = sample();
        mv = |o.req;
        if (o.req[0]) mv_to = 2'd0;
        if (o.req[1]) mv_to = 2'd1;
        if (o.req[2]) mv_to = 2'd2;
        if (o.req[3]) mv_to = 2'd3;
    endtask

    task automatic test_reset();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd0;
        bus.dir   = UP;
        plan.push_back(st(4'b1111, UP, 4'b0000, 4'b0000, 0, 0, 0));
        plan.push_back(st(4'b1111, UP, 4'b0000, 4'b0000, 0, 0, 0));
        repeat (3) plan.push_back(st(4'b0000, UP, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    task automatic test_single_call();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd0;
        plan.push_back(st(4'b0100, UP, 4'b0000, 4'b0100, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, UP, 4'b0100, 4'b0100, 0, 1));
        repeat (4) plan.push_back(st(4'b0000, UP, 4'b0000, 4'b0000, 1, 1));
        repeat (2) plan.push_back(st(4'b0000, UP, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL single_call[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    task automatic test_scan_up_down();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd1;
        plan.push_back(st(4'b1001, UP, 4'b0000, 4'b1001, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, UP, 4'b1000, 4'b1001, 0, 1));
        repeat (4) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0001, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0001, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, DOWN, 4'b0001, 4'b0001, 0, 1));
        repeat (4) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL scan_up_down[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    task automatic test_serve_current();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd2;
        plan.push_back(st(4'b0110, DOWN, 4'b0000, 4'b0110, 0, 0));
        repeat (4) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0010, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0010, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, DOWN, 4'b0010, 4'b0010, 0, 1));
        repeat (4) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL serve_current[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    task automatic test_dwell_absorb();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd2;
        plan.push_back(st(4'b0100, DOWN, 4'b0000, 4'b0100, 0, 0));
        plan.push_back(st(4'b0100, DOWN, 4'b0000, 4'b0000, 1, 1));
        plan.push_back(st(4'b0101, DOWN, 4'b0000, 4'b0001, 1, 1));
        repeat (2) plan.push_back(st(4'b0100, DOWN, 4'b0000, 4'b0001, 1, 1));
        plan.push_back(st(4'b0100, DOWN, 4'b0000, 4'b0001, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, DOWN, 4'b0001, 4'b0001, 0, 1));
        repeat (4) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL dwell_absorb[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_req();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd0;
        plan.push_back(st(4'b1000, UP, 4'b0000, 4'b1000, 0, 0));
        plan.push_back(st(4'b0000, UP, 4'b1000, 4'b1000, 0, 1));
        plan.push_back(st(4'b0000, UP, 4'b0000, 4'b0000, 0, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, UP, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset_mid_req[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        obs_t  got;
        obs_t  e;
        int    cyc = 0;
        bus.floor = 2'd3;
        plan.push_back(st(4'b0001, DOWN, 4'b0000, 4'b0001, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, DOWN, 4'b0001, 4'b0001, 0, 1));
        plan.push_back(st(4'b0001, DOWN, 4'b0000, 4'b0000, 1, 1));
        plan.push_back(st(4'b0010, DOWN, 4'b0000, 4'b0010, 1, 1));
        repeat (2) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0010, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0010, 0, 0));
        repeat (2) plan.push_back(st(4'b0000, DOWN, 4'b0010, 4'b0010, 0, 1));
        repeat (4) plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 1, 1));
        plan.push_back(st(4'b0000, DOWN, 4'b0000, 4'b0000, 0, 0));
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.btn = s.btn;
            bus.dir = s.dir;
            rst     = s.rst;
            sb.push_back(s.exp);
            clk_step();
            got = sample();
            e   = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL back_to_back[%0d] got req=%b pend=%b door=%b busy=%b want req=%b pend=%b door=%b busy=%b",
                         cyc, got.req, got.pend, got.door, got.busy, e.req, e.pend, e.door, e.busy);
            end
            cyc++;
        end
    endtask

    initial begin
        bus.btn   = 4'b0000;
        bus.floor = 2'd0;
        bus.dir   = UP;
        test_reset();
        test_single_call();
        test_scan_up_down();
        test_serve_current();
        test_dwell_absorb();
        test_reset_mid_req();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
